// File: rtl/dp_types_pkg.sv
// Shared datapath constants and helpers for the branch target buffer.
package dp_types_pkg;

   // Instructions are word aligned, so the two lowest PC bits carry no information.
   localparam int unsigned BTB_PC_LSB = 2;
   localparam int unsigned WORD_W     = 32;

   // Initial direction counter value for a freshly allocated entry: weakly taken or
   // weakly not-taken. Sized for the widest counter; callers truncate to their width.
   function automatic logic [3:0] ctr_init(input int unsigned ctr_bits, input logic taken);
      logic [3:0] half;
      half = 4'(1 << (ctr_bits - 1));
      return taken ? half : half - 4'd1;
   endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Picks the way to overwrite on an allocate: lowest invalid way, else round-robin.
module btb_victim_sel #(
   parameter int unsigned WAYS = 2,
   parameter int unsigned RR_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic [WAYS-1:0] valid_i,
   input  logic [RR_W-1:0] rr_i,
   output logic [RR_W-1:0] victim_o,
   output logic            adv_rr_o
);

   // Scan from the top down so the lowest-index invalid way wins.
   always_comb begin
      victim_o = rr_i;
      adv_rr_o = 1'b1;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid_i[i]) begin
            victim_o = RR_W'(i);
            adv_rr_o = 1'b0;
         end
      end
   end

endmodule

// File: rtl/set_assoc_btb.sv
// Set-associative branch target buffer with per-entry saturating direction counters.
// Looked up combinationally with the fetch PC, trained at the clock edge.
module set_assoc_btb
   import dp_types_pkg::*;
#(
   parameter int unsigned SETS     = 16,
   parameter int unsigned WAYS     = 2,
   parameter int unsigned CTR_BITS = 2
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic [WORD_W-1:0] rd_pc,
   output logic              rd_hit,
   output logic              rd_taken,
   output logic [WORD_W-1:0] rd_target,
   input  logic              upd_en,
   input  logic [WORD_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [WORD_W-1:0] upd_target,
   input  logic              flush,
   output logic [WORD_W-1:0] hit_cnt,
   output logic [WORD_W-1:0] upd_cnt
);

   localparam int unsigned IDX   = $clog2(SETS);
   localparam int unsigned TAG_W = WORD_W - BTB_PC_LSB - IDX;
   // With a single way the round-robin pointer is meaningless; keep one bit tied to 0.
   localparam int unsigned RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef struct packed {
      logic                valid;
      logic [TAG_W-1:0]    tag;
      logic [WORD_W-1:0]   target;
      logic [CTR_BITS-1:0] ctr;
   } btb_entry_t;

   function automatic logic [CTR_BITS-1:0] sat_ctr(input logic [CTR_BITS-1:0] c,
                                                   input logic up);
      if (up) return (c == {CTR_BITS{1'b1}}) ? c : c + 1'b1;
      else    return (c == '0) ? c : c - 1'b1;
   endfunction

   btb_entry_t        table_q [SETS][WAYS];
   logic [RR_W-1:0]   rr_q    [SETS];
   logic [WORD_W-1:0] hit_cnt_q, upd_cnt_q;

   logic [IDX-1:0]    rd_idx, upd_idx;
   logic [TAG_W-1:0]  rd_tag, upd_tag;
   logic              upd_hit;
   logic [RR_W-1:0]   hit_way, victim_way, upd_way;
   logic              adv_rr;
   logic [WAYS-1:0]   upd_valid_vec;
   logic [RR_W-1:0]   rr_d;
   btb_entry_t        upd_entry_d;
   logic              unused_pc_lsbs;

   assign rd_idx  = rd_pc[BTB_PC_LSB +: IDX];
   assign rd_tag  = rd_pc[WORD_W-1 -: TAG_W];
   assign upd_idx = upd_pc[BTB_PC_LSB +: IDX];
   assign upd_tag = upd_pc[WORD_W-1 -: TAG_W];
   assign unused_pc_lsbs = ^{rd_pc[BTB_PC_LSB-1:0], upd_pc[BTB_PC_LSB-1:0]};

   // Zero-latency lookup; at most one way can match, so the last match is the only one.
   always_comb begin
      rd_hit    = 1'b0;
      rd_taken  = 1'b0;
      rd_target = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (table_q[rd_idx][w].valid && table_q[rd_idx][w].tag == rd_tag) begin
            rd_hit    = 1'b1;
            rd_taken  = table_q[rd_idx][w].ctr[CTR_BITS-1];
            rd_target = table_q[rd_idx][w].target;
         end
      end
   end

   // Tag match in the training set, plus the valid vector for victim selection.
   always_comb begin
      upd_hit = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         upd_valid_vec[w] = table_q[upd_idx][w].valid;
         if (table_q[upd_idx][w].valid && table_q[upd_idx][w].tag == upd_tag) begin
            upd_hit = 1'b1;
            hit_way = RR_W'(w);
         end
      end
   end

   btb_victim_sel #(
      .WAYS (WAYS),
      .RR_W (RR_W)
   ) u_victim_sel (
      .valid_i  (upd_valid_vec),
      .rr_i     (rr_q[upd_idx]),
      .victim_o (victim_way),
      .adv_rr_o (adv_rr)
   );

   // Next contents of the trained way and the set's round-robin pointer.
   always_comb begin
      upd_way     = upd_hit ? hit_way : victim_way;
      upd_entry_d = table_q[upd_idx][upd_way];
      rr_d        = rr_q[upd_idx];
      if (upd_hit) begin
         upd_entry_d.ctr = sat_ctr(upd_entry_d.ctr, upd_taken);
         if (upd_taken) upd_entry_d.target = upd_target;
      end else begin
         upd_entry_d.valid  = 1'b1;
         upd_entry_d.tag    = upd_tag;
         upd_entry_d.target = upd_target;
         upd_entry_d.ctr    = CTR_BITS'(ctr_init(CTR_BITS, upd_taken));
         if (adv_rr && WAYS > 1) rr_d = rr_q[upd_idx] + 1'b1;
      end
   end

   // Table, pointers and statistics; flush wins over training but not over counting.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int s = 0; s < SETS; s++) begin
            rr_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) table_q[s][w] <= '0;
         end
         hit_cnt_q <= '0;
         upd_cnt_q <= '0;
      end else begin
         if (upd_en) begin
            upd_cnt_q <= upd_cnt_q + 1'b1;
            if (upd_hit) hit_cnt_q <= hit_cnt_q + 1'b1;
         end
         if (flush) begin
            for (int s = 0; s < SETS; s++) begin
               rr_q[s] <= '0;
               for (int w = 0; w < WAYS; w++) table_q[s][w].valid <= 1'b0;
            end
         end else if (upd_en) begin
            table_q[upd_idx][upd_way] <= upd_entry_d;
            rr_q[upd_idx]             <= rr_d;
         end
      end
   end

   assign hit_cnt = hit_cnt_q;
   assign upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_set_assoc_btb.sv
// Directed self-checking bench for set_assoc_btb (SETS=16, WAYS=2, CTR_BITS=2).
module tb_set_assoc_btb;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [31:0] rd_pc;
   logic        rd_hit, rd_taken;
   logic [31:0] rd_target;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush;
   logic [31:0] hit_cnt, upd_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   set_assoc_btb #(
      .SETS     (16),
      .WAYS     (2),
      .CTR_BITS (2)
   ) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .rd_pc      (rd_pc),
      .rd_hit     (rd_hit),
      .rd_taken   (rd_taken),
      .rd_target  (rd_target),
      .upd_en     (upd_en),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target),
      .flush      (flush),
      .hit_cnt    (hit_cnt),
      .upd_cnt    (upd_cnt)
   );

   always #5 CLK = ~CLK;

   // One training edge; inputs change 1 time unit after the rising edge.
   task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      upd_pc     = pc;
      upd_taken  = tk;
      upd_target = tgt;
      upd_en     = 1'b1;
      @(posedge CLK);
      #1;
      upd_en = 1'b0;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      #2;
      nRST = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      nRST = 1'b0; upd_en = 1'b0; flush = 1'b0;
      upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
      rd_pc = 32'h40;
      #3;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b exp 0", rd_hit); end
      n_checks++;
      if (rd_taken !== 1'b0) begin
         n_fail++; $display("FAIL reset_taken got %b exp 0", rd_taken);
      end
      n_checks++;
      if (rd_target !== 32'h0) begin
         n_fail++; $display("FAIL reset_target got %h exp 0", rd_target);
      end
      n_checks++;
      if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_hitcnt got %0d exp 0", hit_cnt); end
      n_checks++;
      if (upd_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_updcnt got %0d exp 0", upd_cnt); end
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_train();
      rd_pc = 32'h40;
      train(32'h40, 1'b1, 32'h100);      // allocate, ctr=2
      #1;
      n_checks++;
      if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b1, 32'h100}) begin
         n_fail++;
         $display("FAIL train_alloc got hit=%b tk=%b tgt=%h exp 1 1 00000100",
                  rd_hit, rd_taken, rd_target);
      end
      train(32'h40, 1'b0, 32'h999);      // ctr 2->1, target kept
      #1;
      n_checks++;
      if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL train_nt1 got hit=%b tk=%b tgt=%h exp 1 0 00000100",
                  rd_hit, rd_taken, rd_target);
      end
      train(32'h40, 1'b0, 32'h999);      // ctr 1->0
      train(32'h40, 1'b0, 32'h999);      // ctr stays 0 (a wrap would read taken)
      #1;
      n_checks++;
      if ({rd_taken, rd_target} !== {1'b0, 32'h100}) begin
         n_fail++;
         $display("FAIL train_sat_lo got tk=%b tgt=%h exp 0 00000100", rd_taken, rd_target);
      end
      train(32'h40, 1'b1, 32'h200);      // ctr 0->1, target replaced
      #1;
      n_checks++;
      if ({rd_taken, rd_target} !== {1'b0, 32'h200}) begin
         n_fail++;
         $display("FAIL train_up1 got tk=%b tgt=%h exp 0 00000200", rd_taken, rd_target);
      end
      train(32'h40, 1'b1, 32'h200);      // ctr 1->2
      train(32'h40, 1'b1, 32'h200);      // ctr 2->3
      train(32'h40, 1'b1, 32'h200);      // stays 3
      train(32'h40, 1'b0, 32'h200);      // 3->2, still taken
      #1;
      n_checks++;
      if (rd_taken !== 1'b1) begin n_fail++; $display("FAIL train_sat_hi got %b exp 1", rd_taken); end
      n_checks++;
      if (upd_cnt !== 32'd9) begin n_fail++; $display("FAIL train_updcnt got %0d exp 9", upd_cnt); end
      n_checks++;
      if (hit_cnt !== 32'd8) begin n_fail++; $display("FAIL train_hitcnt got %0d exp 8", hit_cnt); end
   endtask

   task automatic test_conflict();
      do_reset();
      train(32'h40, 1'b1, 32'h400);      // way 0
      train(32'h80, 1'b0, 32'h800);      // way 1, weakly not-taken
      rd_pc = 32'h80;
      #1;
      n_checks++;
      if ({rd_hit, rd_taken, rd_target} !== {1'b1, 1'b0, 32'h800}) begin
         n_fail++;
         $display("FAIL conf_nt_alloc got hit=%b tk=%b tgt=%h exp 1 0 00000800",
                  rd_hit, rd_taken, rd_target);
      end
      train(32'hC0, 1'b1, 32'hC00);      // evicts way 0 (0x40)
      rd_pc = 32'h40; #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL conf_evict40 got %b exp 0", rd_hit); end
      rd_pc = 32'h80; #1;
      n_checks++;
      if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL conf_keep80 got %b exp 1", rd_hit); end
      rd_pc = 32'hC0; #1;
      n_checks++;
      if ({rd_hit, rd_target} !== {1'b1, 32'hC00}) begin
         n_fail++; $display("FAIL conf_hitC0 got hit=%b tgt=%h exp 1 00000c00", rd_hit, rd_target);
      end
      train(32'h100, 1'b1, 32'h1000);    // evicts way 1 (0x80)
      rd_pc = 32'h80; #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL conf_evict80 got %b exp 0", rd_hit); end
      rd_pc = 32'hC0; #1;
      n_checks++;
      if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL conf_keepC0 got %b exp 1", rd_hit); end
      rd_pc = 32'h100; #1;
      n_checks++;
      if ({rd_hit, rd_target} !== {1'b1, 32'h1000}) begin
         n_fail++; $display("FAIL conf_hit100 got hit=%b tgt=%h exp 1 00001000", rd_hit, rd_target);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      rd_pc = 32'h40;
      upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h500; upd_en = 1'b1;
      #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_pre got %b exp 0", rd_hit); end
      @(posedge CLK);
      #1;
      upd_en = 1'b0;
      n_checks++;
      if ({rd_hit, rd_target} !== {1'b1, 32'h500}) begin
         n_fail++; $display("FAIL same_cycle_post got hit=%b tgt=%h exp 1 00000500", rd_hit, rd_target);
      end
   endtask

   task automatic test_flush();
      do_reset();
      train(32'h40, 1'b1, 32'h1);
      train(32'h80, 1'b1, 32'h2);
      train(32'hC0, 1'b1, 32'h3);        // rr now 1
      flush = 1'b1;
      train(32'hC0, 1'b1, 32'h4);        // hit, but flush wins
      flush = 1'b0;
      n_checks++;
      if (upd_cnt !== 32'd4) begin n_fail++; $display("FAIL flush_updcnt got %0d exp 4", upd_cnt); end
      n_checks++;
      if (hit_cnt !== 32'd1) begin n_fail++; $display("FAIL flush_hitcnt got %0d exp 1", hit_cnt); end
      rd_pc = 32'hC0; #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL flush_missC0 got %b exp 0", rd_hit); end
      rd_pc = 32'h80; #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL flush_miss80 got %b exp 0", rd_hit); end
      // rr was cleared: the third allocate must evict way 0 again
      train(32'h40, 1'b1, 32'h1);
      train(32'h80, 1'b1, 32'h2);
      train(32'hC0, 1'b1, 32'h3);
      rd_pc = 32'h40; #1;
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL flush_rr40 got %b exp 0", rd_hit); end
      rd_pc = 32'h80; #1;
      n_checks++;
      if (rd_hit !== 1'b1) begin n_fail++; $display("FAIL flush_rr80 got %b exp 1", rd_hit); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      train(32'h40, 1'b1, 32'h10);       // miss
      train(32'h44, 1'b0, 32'h20);       // miss, set 1
      train(32'h40, 1'b1, 32'h10);       // hit
      train(32'h44, 1'b1, 32'h20);       // hit
      train(32'h40, 1'b0, 32'h10);       // hit
      n_checks++;
      if (upd_cnt !== 32'd5) begin n_fail++; $display("FAIL b2b_updcnt got %0d exp 5", upd_cnt); end
      n_checks++;
      if (hit_cnt !== 32'd3) begin n_fail++; $display("FAIL b2b_hitcnt got %0d exp 3", hit_cnt); end
      rd_pc = 32'h44; #1;
      n_checks++;
      if ({rd_hit, rd_taken} !== {1'b1, 1'b1}) begin
         n_fail++; $display("FAIL b2b_hit44 got hit=%b tk=%b exp 1 1", rd_hit, rd_taken);
      end
      // Reset between edges with a pending update must clear everything at once.
      rd_pc = 32'h40;
      upd_pc = 32'h40; upd_taken = 1'b1; upd_en = 1'b1;
      #2;
      nRST = 1'b0;
      #1;
      n_checks++;
      if (upd_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_updcnt got %0d exp 0", upd_cnt); end
      n_checks++;
      if (hit_cnt !== 32'd0) begin n_fail++; $display("FAIL midrst_hitcnt got %0d exp 0", hit_cnt); end
      n_checks++;
      if (rd_hit !== 1'b0) begin n_fail++; $display("FAIL midrst_hit got %b exp 0", rd_hit); end
      @(posedge CLK);
      #1;
      upd_en = 1'b0;
      nRST = 1'b1;
      #1;
      n_checks++;
      if ({rd_hit, upd_cnt} !== {1'b0, 32'd0}) begin
         n_fail++; $display("FAIL midrst_hold got hit=%b upd=%0d exp 0 0", rd_hit, upd_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_train();
      test_conflict();
      test_same_cycle();
      test_flush();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
